// File: rtl/hd_timing_pkg.sv
// ---------------------------------------------------------------------------
// hd_timing_pkg
// Shared HD raster timing for the PAL-to-HD path. The raster generator and
// the upsampler both take their line/frame geometry from here, so the active
// width seen by the upsampler always matches the DE window of the generator.
//
// Contents:
//   H_/V_ timing constants, H_TOTAL/V_TOTAL, counter widths,
//   f_lock_err : shortest circular distance between two line numbers.
// ---------------------------------------------------------------------------
package hd_timing_pkg;

  localparam int H_ACT   = 1360;
  localparam int H_FP    = 64;
  localparam int H_SYNC  = 112;
  localparam int H_BP    = 256;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;

  localparam int V_ACT   = 768;
  localparam int V_FP    = 3;
  localparam int V_SYNC  = 6;
  localparam int V_BP    = 18;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  // Active width handed to the upsampler.
  localparam int HD_H_RES = H_ACT;

  localparam int H_CNT_W = 12;
  localparam int V_CNT_W = 11;

  // Distance between the line the raster would have reached (i_vn) and the
  // line a genlock forces it to (i_lock), measured the short way round a
  // frame of i_vtot lines. Both line numbers must already be < i_vtot.
  function automatic logic [V_CNT_W-1:0] f_lock_err(
    input logic [V_CNT_W-1:0] i_vn,
    input logic [V_CNT_W-1:0] i_lock,
    input logic [V_CNT_W-1:0] i_vtot
  );
    logic [V_CNT_W-1:0] w_dist;
    w_dist = (i_vn >= i_lock) ? (i_vn - i_lock) : (i_vn + i_vtot - i_lock);
    return (w_dist > (i_vtot >> 1)) ? (i_vtot - w_dist) : w_dist;
  endfunction

endpackage

// File: rtl/hd_nco.sv
// ---------------------------------------------------------------------------
// hd_nco
// Phase-accumulator pixel clock. Every carry out of the accumulator toggles
// o_hd_clk, so the toggle rate is clk*PHASE_INC/2^ACC_W and the pixel rate is
// half of that. Each falling toggle of o_hd_clk is one pixel.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   o_hd_clk   out  pixel-rate square wave
//   o_pix_en   out  registered one-clk pulse, high while o_hd_clk has just
//                   fallen
//   o_pix_adv  out  combinational: the coming clk edge is a falling toggle.
//                   Registers that must change together with o_pix_en use
//                   this as their enable.
// ---------------------------------------------------------------------------
module hd_nco #(
  parameter int          ACC_W     = 16,
  parameter int unsigned PHASE_INC = 0
) (
  input  logic clk,
  input  logic rst,
  output logic o_hd_clk,
  output logic o_pix_en,
  output logic o_pix_adv
);

  localparam logic [ACC_W-1:0] C_INC = ACC_W'(PHASE_INC);

  logic [ACC_W-1:0] r_acc;
  logic             r_hd_clk;
  logic             r_pix_en;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;

  // One extra bit on the sum exposes the wrap of the accumulator.
  assign w_sum     = {1'b0, r_acc} + {1'b0, C_INC};
  assign w_carry   = w_sum[ACC_W];
  assign o_pix_adv = w_carry & r_hd_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_hd_clk <= 1'b0;
      r_pix_en <= 1'b0;
    end else begin
      r_acc    <= w_sum[ACC_W-1:0];
      r_pix_en <= o_pix_adv;
      if (w_carry) begin
        r_hd_clk <= ~r_hd_clk;
      end
    end
  end

  assign o_hd_clk = r_hd_clk;
  assign o_pix_en = r_pix_en;

endmodule

// File: rtl/hd_sync_gen.sv
// ---------------------------------------------------------------------------
// hd_sync_gen
// HD raster timing generator. An NCO derives the pixel rate from clk; pixel
// and line counters, registered DE/HSYNC/VSYNC decodes and a genlock that
// pulls the vertical counter onto the PAL frame boundary run in clk.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active high
//   i_lock_en    in   1 = genlock to i_frame_end, 0 = free-run
//   i_frame_end  in   one-clk frame-end pulse from the upsampler
//   o_hd_clk     out  pixel-rate square wave
//   o_pix_en     out  one-clk pulse per pixel (o_hd_clk falling)
//   o_hd_hsync   out  active-high hsync
//   o_hd_vsync   out  active-high vsync
//   o_de         out  active-pixel enable
//   o_h_cnt      out  pixel counter 0..H_TOTAL-1
//   o_v_cnt      out  line counter 0..V_TOTAL-1
//   o_locked     out  genlock status
//
// Counters and decodes all change on the clk where o_pix_en goes high, so a
// consumer sees a consistent (h, v, de, syncs) tuple alongside o_pix_en.
// A genlock never cuts a line: the vertical load waits for the next wrap of
// the pixel counter.
// ---------------------------------------------------------------------------
module hd_sync_gen #(
  parameter int          H_ACT     = hd_timing_pkg::H_ACT,
  parameter int          H_FP      = hd_timing_pkg::H_FP,
  parameter int          H_SYNC    = hd_timing_pkg::H_SYNC,
  parameter int          H_BP      = hd_timing_pkg::H_BP,
  parameter int          V_ACT     = hd_timing_pkg::V_ACT,
  parameter int          V_FP      = hd_timing_pkg::V_FP,
  parameter int          V_SYNC    = hd_timing_pkg::V_SYNC,
  parameter int          V_BP      = hd_timing_pkg::V_BP,
  parameter int          ACC_W     = 16,
  parameter int unsigned PHASE_INC = 0,
  parameter int          LOCK_LINE = 0,
  parameter int          LOCK_TOL  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_lock_en,
  input  logic                              i_frame_end,
  output logic                              o_hd_clk,
  output logic                              o_pix_en,
  output logic                              o_hd_hsync,
  output logic                              o_hd_vsync,
  output logic                              o_de,
  output logic [hd_timing_pkg::H_CNT_W-1:0] o_h_cnt,
  output logic [hd_timing_pkg::V_CNT_W-1:0] o_v_cnt,
  output logic                              o_locked
);

  localparam int HW = hd_timing_pkg::H_CNT_W;
  localparam int VW = hd_timing_pkg::V_CNT_W;

  localparam int H_TOTAL_L = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_L = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] C_H_LAST    = HW'(H_TOTAL_L - 1);
  localparam logic [HW-1:0] C_H_ACT     = HW'(H_ACT);
  localparam logic [HW-1:0] C_HS_BEG    = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] C_HS_END    = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] C_V_LAST    = VW'(V_TOTAL_L - 1);
  localparam logic [VW-1:0] C_V_TOTAL   = VW'(V_TOTAL_L);
  localparam logic [VW-1:0] C_V_ACT     = VW'(V_ACT);
  localparam logic [VW-1:0] C_VS_BEG    = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] C_VS_END    = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic [VW-1:0] C_LOCK_LINE = VW'(LOCK_LINE);
  localparam logic [VW-1:0] C_LOCK_TOL  = VW'(LOCK_TOL);
  // Watchdog span in lines; one bit wider than the line counter.
  localparam logic [VW:0]   C_WD_LIM    = (VW + 1)'(2 * V_TOTAL_L);

  // ---------------------------------------------------------------- NCO
  logic w_pix_adv;

  hd_nco #(
    .ACC_W     (ACC_W),
    .PHASE_INC (PHASE_INC)
  ) u_nco (
    .clk       (clk),
    .rst       (rst),
    .o_hd_clk  (o_hd_clk),
    .o_pix_en  (o_pix_en),
    .o_pix_adv (w_pix_adv)
  );

  // ---------------------------------------------------------------- state
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          r_de;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_lock_pending;
  logic [1:0]    r_good_cnt;
  logic          r_locked;
  logic [VW:0]   r_wd_cnt;

  // ---------------------------------------------------------------- next-state
  logic          w_h_wrap;
  logic          w_line;
  logic          w_load;
  logic          w_pending_next;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_inc;
  logic [VW-1:0] w_v_next;
  logic [VW-1:0] w_err;
  logic [1:0]    w_good_inc;

  always_comb begin
    w_h_wrap       = 1'b0;
    w_line         = 1'b0;
    w_load         = 1'b0;
    w_pending_next = r_lock_pending;
    w_h_next       = r_h_cnt;
    w_v_inc        = r_v_cnt;
    w_v_next       = r_v_cnt;
    w_err          = '0;
    w_good_inc     = r_good_cnt;

    w_h_wrap = (r_h_cnt == C_H_LAST);
    w_line   = w_pix_adv && w_h_wrap;
    w_h_next = w_h_wrap ? '0 : r_h_cnt + 1'b1;
    w_v_inc  = (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 1'b1;

    // A frame-end arriving on the wrap clk itself is honoured at that wrap,
    // hence the direct i_frame_end term alongside the pending flag.
    w_load = w_line && i_lock_en && (r_lock_pending || i_frame_end);

    if (w_line) begin
      w_v_next = w_load ? C_LOCK_LINE : w_v_inc;
    end

    // Error is judged against where the raster would have gone without the load.
    w_err      = hd_timing_pkg::f_lock_err(w_v_inc, C_LOCK_LINE, C_V_TOTAL);
    w_good_inc = (r_good_cnt == 2'd3) ? 2'd3 : r_good_cnt + 2'd1;

    // Repeated pulses while pending just keep the flag set: one load only.
    if (!i_lock_en) begin
      w_pending_next = 1'b0;
    end else if (w_load) begin
      w_pending_next = 1'b0;
    end else if (i_frame_end) begin
      w_pending_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt        <= '0;
      r_v_cnt        <= '0;
      r_de           <= 1'b0;
      r_hsync        <= 1'b0;
      r_vsync        <= 1'b0;
      r_lock_pending <= 1'b0;
      r_good_cnt     <= 2'd0;
      r_locked       <= 1'b0;
      r_wd_cnt       <= '0;
    end else begin
      r_lock_pending <= w_pending_next;

      // Decodes are taken from the next counter values so they land on the
      // same clk as the counters themselves.
      if (w_pix_adv) begin
        r_h_cnt <= w_h_next;
        r_v_cnt <= w_v_next;
        r_de    <= (w_h_next < C_H_ACT) && (w_v_next < C_V_ACT);
        r_hsync <= (w_h_next >= C_HS_BEG) && (w_h_next < C_HS_END);
        r_vsync <= (w_v_next >= C_VS_BEG) && (w_v_next < C_VS_END);
      end

      if (w_load) begin
        r_wd_cnt <= '0;
        if (w_err <= C_LOCK_TOL) begin
          r_good_cnt <= w_good_inc;
          r_locked   <= (w_good_inc == 2'd3);
        end else begin
          r_good_cnt <= 2'd0;
          r_locked   <= 1'b0;
        end
      end else if (w_line) begin
        // Lines without a genlock load; saturates so it never rolls back
        // into the "recently loaded" range.
        if (r_wd_cnt < C_WD_LIM) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
        if (r_wd_cnt >= C_WD_LIM - 1'b1) begin
          r_good_cnt <= 2'd0;
          r_locked   <= 1'b0;
        end
      end
    end
  end

  assign o_h_cnt    = r_h_cnt;
  assign o_v_cnt    = r_v_cnt;
  assign o_de       = r_de;
  assign o_hd_hsync = r_hsync;
  assign o_hd_vsync = r_vsync;
  assign o_locked   = r_locked;

endmodule

// File: tb/tb_hd_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_hd_sync_gen
// Directed bench on a reduced raster: H 8/2/2/4 (16 pixels), V 4/1/1/2
// (8 lines), PHASE_INC = 2^15 so o_hd_clk toggles every 2 clk and a pixel
// lands every 4 clk. A second instance with PHASE_INC = 0 must stay frozen.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hd_sync_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lock_en = 1'b0;
  logic        frame_end = 1'b0;

  logic        hd_clk, pix_en, hsync, vsync, de, locked;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;

  logic        frz_lock_en = 1'b0;
  logic        frz_frame_end = 1'b0;
  logic        frz_hd_clk, frz_pix_en, frz_hsync, frz_vsync, frz_de, frz_locked;
  logic [11:0] frz_h_cnt;
  logic [10:0] frz_v_cnt;

  int n_vec = 0;
  int n_err = 0;
  int frz_bad = 0;
  int frz_samples = 0;

  // Hand-derived decode tables for the reduced raster (bit index = counter).
  logic [15:0] de_h_mask = 16'h00FF;  // h 0..7 active
  logic [15:0] hs_mask   = 16'h0C00;  // h 10..11 sync
  logic [7:0]  de_v_mask = 8'h0F;     // v 0..3 active
  logic [7:0]  vs_mask   = 8'h20;     // v 5 sync

  always #5 clk = ~clk;

  hd_sync_gen #(
    .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .ACC_W(16), .PHASE_INC(32768), .LOCK_LINE(0), .LOCK_TOL(2)
  ) u_dut (
    .clk(clk), .rst(rst), .i_lock_en(lock_en), .i_frame_end(frame_end),
    .o_hd_clk(hd_clk), .o_pix_en(pix_en), .o_hd_hsync(hsync), .o_hd_vsync(vsync),
    .o_de(de), .o_h_cnt(h_cnt), .o_v_cnt(v_cnt), .o_locked(locked)
  );

  hd_sync_gen #(
    .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .ACC_W(16), .PHASE_INC(0), .LOCK_LINE(0), .LOCK_TOL(2)
  ) u_frz (
    .clk(clk), .rst(rst), .i_lock_en(frz_lock_en), .i_frame_end(frz_frame_end),
    .o_hd_clk(frz_hd_clk), .o_pix_en(frz_pix_en), .o_hd_hsync(frz_hsync),
    .o_hd_vsync(frz_vsync), .o_de(frz_de), .o_h_cnt(frz_h_cnt),
    .o_v_cnt(frz_v_cnt), .o_locked(frz_locked)
  );

  // Frozen raster: every output must stay at its reset value.
  always @(negedge clk) begin
    if (!rst) begin
      frz_samples++;
      if ({frz_hd_clk, frz_pix_en, frz_hsync, frz_vsync, frz_de, frz_locked} != 6'd0 ||
          frz_h_cnt != 12'd0 || frz_v_cnt != 11'd0) begin
        frz_bad++;
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next pixel; returns at the falling edge where o_pix_en is high.
  task automatic step_pix(output int ncyc);
    ncyc = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (!pix_en && ncyc < 16);
    if (!pix_en) check_vec("pix_timeout", 32'(pix_en), 32'd1);
  endtask

  // Advance to the next line start (h_cnt back to 0).
  task automatic step_line();
    int nc;
    int guard;
    guard = 0;
    do begin
      step_pix(nc);
      guard++;
    end while (h_cnt != 12'd0 && guard < 20);
    check_vec("line_wrap_seen", 32'(h_cnt), 32'd0);
  endtask

  // Wait for the pixel edge at (h, v).
  task automatic goto_pix(input int h, input int v);
    int found;
    found = 0;
    for (int c = 0; c < 1200 && found == 0; c++) begin
      @(negedge clk);
      if (pix_en && h_cnt == 12'(h) && v_cnt == 11'(v)) found = 1;
    end
    check_vec($sformatf("goto_%0d_%0d", h, v), 32'(found), 32'd1);
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  // Three frame-ends on the last line: each load lands exactly on time.
  task automatic lock_three();
    for (int k = 0; k < 3; k++) begin
      goto_pix(5, 7);
      pulse_fe();
      step_line();
      check_vec($sformatf("lock_v_%0d", k), 32'(v_cnt), 32'd0);
      check_vec($sformatf("lock_state_%0d", k), 32'(locked), (k == 2) ? 32'd1 : 32'd0);
      $display("genlock on-time load %0d: v=%0d locked=%0d", k, v_cnt, locked);
    end
  endtask

  initial begin
    int nc;
    int eh;
    int ev;
    logic [3:0] wav;
    logic pe1;

    // ---------------- reset values
    repeat (4) @(negedge clk);
    check_vec("rst_flags", 32'({hd_clk, pix_en, hsync, vsync, de, locked}), 32'd0);
    check_vec("rst_h", 32'(h_cnt), 32'd0);
    check_vec("rst_v", 32'(v_cnt), 32'd0);
    rst = 1'b0;
    $display("reset released");

    // ---------------- free-running raster, a frame plus a bit
    eh = 0;
    ev = 0;
    for (int i = 0; i < 130; i++) begin
      step_pix(nc);
      check_vec("pix_period", 32'(nc), 32'd4);
      eh = (eh == 15) ? 0 : eh + 1;
      if (eh == 0) ev = (ev == 7) ? 0 : ev + 1;
      check_vec($sformatf("h@%0d", i), 32'(h_cnt), 32'(eh));
      check_vec($sformatf("v@%0d", i), 32'(v_cnt), 32'(ev));
      check_vec($sformatf("de@%0d_%0d", eh, ev), 32'(de), 32'(de_h_mask[eh] & de_v_mask[ev]));
      check_vec($sformatf("hs@%0d", eh), 32'(hsync), 32'(hs_mask[eh]));
      check_vec($sformatf("vs@%0d_%0d", eh, ev), 32'(vsync), 32'(vs_mask[ev]));
    end
    $display("raster frame walked: ended at h=%0d v=%0d", h_cnt, v_cnt);

    // ---------------- hd_clk shape between two pixels: 0,1,1,0 and 1-clk pix_en
    @(negedge clk); wav[3] = hd_clk; pe1 = pix_en;
    @(negedge clk); wav[2] = hd_clk;
    @(negedge clk); wav[1] = hd_clk;
    @(negedge clk); wav[0] = hd_clk;
    check_vec("hd_clk_wave", 32'(wav), 32'h6);
    check_vec("pix_en_width", 32'(pe1), 32'd0);
    check_vec("pix_en_next", 32'(pix_en), 32'd1);
    $display("hd_clk wave %b", wav);

    // ---------------- frozen instance
    check_vec("frz_changes", 32'(frz_bad), 32'd0);
    check_vec("frz_samples_ge100", 32'(frz_samples >= 100), 32'd1);
    $display("frozen raster: %0d samples", frz_samples);

    // ---------------- genlock mid-line: no short line
    lock_en = 1'b1;
    goto_pix(3, 5);
    pulse_fe();
    for (int k = 4; k < 16; k++) begin
      step_pix(nc);
      check_vec($sformatf("gl_h%0d", k), 32'(h_cnt), 32'(k));
      check_vec($sformatf("gl_v%0d", k), 32'(v_cnt), 32'd5);
    end
    step_pix(nc);
    check_vec("gl_wrap_h", 32'(h_cnt), 32'd0);
    check_vec("gl_wrap_v", 32'(v_cnt), 32'd0);
    $display("genlock mid-line: wrap to v=%0d", v_cnt);

    // ---------------- frame_end on the wrap clk itself
    goto_pix(15, 2);
    repeat (3) @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    check_vec("wrapclk_pix", 32'(pix_en), 32'd1);
    check_vec("wrapclk_h", 32'(h_cnt), 32'd0);
    check_vec("wrapclk_v", 32'(v_cnt), 32'd0);
    step_line();
    check_vec("wrapclk_next_v", 32'(v_cnt), 32'd1);
    $display("genlock on wrap clk: loaded, next line v=%0d", v_cnt);

    // ---------------- two pulses in one line -> one load
    goto_pix(2, 3);
    pulse_fe();
    goto_pix(9, 3);
    pulse_fe();
    step_line();
    check_vec("dbl_v_load", 32'(v_cnt), 32'd0);
    step_line();
    check_vec("dbl_v_after", 32'(v_cnt), 32'd1);
    $display("double pulse: single load, then v=%0d", v_cnt);

    // ---------------- lock acquisition and early frame_end
    lock_three();
    goto_pix(5, 2);
    pulse_fe();
    goto_pix(15, 2);
    check_vec("early_pre_locked", 32'(locked), 32'd1);
    step_pix(nc);
    check_vec("early_v", 32'(v_cnt), 32'd0);
    check_vec("early_locked", 32'(locked), 32'd0);
    $display("early frame_end: locked=%0d", locked);

    // ---------------- watchdog: 2*V_TOTAL = 16 lines without a load
    lock_three();
    for (int n = 1; n < 16; n++) begin
      step_line();
      check_vec($sformatf("wd_hold_%0d", n), 32'(locked), 32'd1);
    end
    step_line();
    check_vec("wd_drop", 32'(locked), 32'd0);
    $display("watchdog: locked=%0d after 16 lines", locked);

    // ---------------- reset mid-frame with a genlock pending
    goto_pix(5, 3);
    pulse_fe();
    goto_pix(7, 3);
    rst = 1'b1;
    @(negedge clk);
    check_vec("mid_rst_flags", 32'({hd_clk, pix_en, hsync, vsync, de, locked}), 32'd0);
    check_vec("mid_rst_h", 32'(h_cnt), 32'd0);
    check_vec("mid_rst_v", 32'(v_cnt), 32'd0);
    rst = 1'b0;
    step_line();
    check_vec("mid_rst_pending_clr", 32'(v_cnt), 32'd1);
    $display("mid-frame reset: restart, first wrap v=%0d", v_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
